param_twisted_counter: RTL
==========================

Name: param_twisted_counter

Overview:
- Parametrised shift-register counter; generalises the fixed 4-bit Johnson counter.
- Adds:
  - configurable width;
  - Johnson or one-hot ring mode;
  - count enable and up/down direction;
  - parallel load;
  - sequence-index decode;
  - wrap pulse;
  - illegal-state detection.
- Used as a low-glitch sequencer/phase generator feeding decode logic in the assignment designs.

Parameters:
- WIDTH, 4, number of flip-flops (>=2).
- MODE, 0, 0 = Johnson (twisted ring, sequence length L = 2*WIDTH); 1 = one-hot ring (L = WIDTH).
- IW (localparam), $clog2(2*WIDTH), width of idx.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance one step per clock when high.
- dir  input  1  0 = forward, 1 = reverse.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value loaded into q.
- q  output  WIDTH  counter state, registered.
- idx  output  IW  position of q in sequence, 0..L-1; combinational decode of q.
- wrap  output  1  registered one-cycle pulse on sequence wrap.
- err  output  1  combinational; high when q is not a legal state for MODE.

Behaviour:
- All state updates on the rising clk edge. Priority: reset > load > en > hold.
- Reset values:
  - q = 0 (MODE 0) or q = 1 (MODE 1, bit0 set).
  - wrap = 0.
  - idx = 0 and err = 0 as a consequence.
  - Reset mid-sequence behaves the same, overriding load and en.
- Load: q <= load_val, regardless of en/dir. wrap <= 0. Illegal values are loaded as-is.
- Step (en=1, load=0):
  - MODE 0 forward: q <= {q[W-2:0], ~q[W-1]}.
  - MODE 0 reverse: q <= {~q[0], q[W-1:1]}.
  - MODE 1 forward: q <= {q[W-2:0], q[W-1]}.
  - MODE 1 reverse: q <= {q[0], q[W-1:1]}.
- Hold (en=0, load=0): q unchanged; wrap <= 0.
- W=4 MODE 0 forward sequence: 0,1,3,7,F,E,C,8,0...
- idx decode:
  - MODE 0, q[W-1]=0: idx = popcount(q).
  - MODE 0, q[W-1]=1: idx = W + (W - popcount(q)). Example W=4: E -> 5, 8 -> 7.
  - MODE 1: idx = index of the set bit.
  - When err=1, idx is 0.
- wrap:
  - Registered; high for exactly one cycle, coincident with q arriving at the wrapped state.
  - Forward step from idx L-1 to 0, or reverse step from idx 0 to L-1.
  - Never asserted by load, reset, or steps out of or into illegal states.
- Legality:
  - MODE 0: legal iff the count of i in 0..W-2 with q[i] != q[i+1] is <= 1.
  - MODE 1: legal iff popcount(q) == 1.
  - err = ~legal.
- Illegal state without correction: shifting rules still apply; err stays high while illegal.
- Simultaneous load and en: load wins. dir is ignored when en=0.

Optional Feature:
- Macro: PARAM_TWISTED_COUNTER_SELF_CORRECT_EN.
- Defined:
  - On any clock edge with err=1, reset=0 and load=0, q <= reset value for MODE and wrap <= 0, regardless of en.
  - err is therefore high for at most one cycle after an illegal load.
- Undefined:
  - No correction; illegal patterns circulate per the shift rules.
  - err reflects every cycle spent in an illegal state.

Test Plan:
1. W=4 MODE 0, reset 2 cycles then en=1 dir=0 for 8 clocks -> q = 1,3,7,F,E,C,8,0; idx = 1..7,0; wrap=1 only in the cycle q=0.
2. From q=0, en=1 dir=1 for 8 clocks -> q = 8,C,E,F,7,3,1,0; wrap=1 only when q=8 (idx 7).
3. At q=3, en=0 for 3 clocks -> q holds 3. Then load=1 load_val=C en=1 -> q=C, idx=6, wrap=0.
4. Load 4'h5 -> err=1, idx=0.
   - With macro: next edge q=0, err=0.
   - Without macro, en=1 dir=0: q = B then 6; err remains 1.
5. W=5 MODE 1, reset -> q=00001. 5 forward steps -> 00010...10000, 00001; wrap once. Load 00000 -> err=1.
6. At q=E with load=1 and en=1, assert reset=1 -> next edge q=0, wrap=0, err=0.

Source files
------------

// File: rtl/param_twisted_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_twisted_counter
// Description : Parametrised shift-register counter. MODE 0 is a Johnson
//               (twisted ring) counter with 2*WIDTH states. MODE 1 is a
//               one-hot ring with WIDTH states. It supports count enable,
//               up/down direction, parallel load, sequence-index decode, a
//               registered wrap pulse and illegal-state detection.
// Optional    : define PARAM_TWISTED_COUNTER_SELF_CORRECT_EN to force any
//               illegal state back to the reset state on the next edge.
// Ports       : clk      - clock, rising edge
//               reset    - synchronous active-high reset
//               en       - advance one step per clock
//               dir      - 0 = forward, 1 = reverse
//               load     - parallel load strobe (wins over en)
//               load_val - value loaded into q (illegal values kept as-is)
//               q        - registered counter state
//               idx      - position of q in the sequence (0 when err)
//               wrap     - registered one-cycle pulse on sequence wrap
//               err      - q is not a legal state for MODE
// Revision    : 1.0 - initial release
// ============================================================================
module param_twisted_counter #(
  parameter int WIDTH = 4,
  parameter int MODE  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          dir,
  input  logic                          load,
  input  logic [WIDTH-1:0]              load_val,
  output logic [WIDTH-1:0]              q,
  output logic [$clog2(2*WIDTH)-1:0]    idx,
  output logic                          wrap,
  output logic                          err
);

  localparam int IW    = $clog2(2*WIDTH);
  // Popcount/index arithmetic needs one bit more than idx to hold 2*WIDTH.
  localparam int PW    = IW + 1;
  localparam int c_len = (MODE == 1) ? WIDTH : 2*WIDTH;

  localparam logic [WIDTH-1:0] c_rst_val  = (MODE == 1) ? WIDTH'(1) : '0;
  localparam logic [IW-1:0]    c_last_idx = IW'(c_len - 1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic             w_fb_fwd;
  logic             w_fb_rev;
  logic [WIDTH-1:0] w_step;
  logic [PW-1:0]    w_pop;
  logic [PW-1:0]    w_edges;
  logic [IW-1:0]    w_oh_idx;
  logic [IW-1:0]    w_idx_raw;
  logic [IW-1:0]    w_idx;
  logic             w_legal;
  logic             w_err;
  logic             w_wrap_nxt;

  // Bit shifted into the vacated end: inverted for the twisted ring.
  if (MODE == 0) begin : g_johnson
    assign w_fb_fwd = ~r_q[WIDTH-1];
    assign w_fb_rev = ~r_q[0];
  end else begin : g_onehot
    assign w_fb_fwd = r_q[WIDTH-1];
    assign w_fb_rev = r_q[0];
  end

  assign w_step = dir ? {w_fb_rev, r_q[WIDTH-1:1]}
                      : {r_q[WIDTH-2:0], w_fb_fwd};

  // Population count, adjacent-bit transition count and set-bit position.
  always_comb begin
    w_pop    = '0;
    w_edges  = '0;
    w_oh_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + PW'(r_q[i]);
      if (r_q[i]) begin
        w_oh_idx = IW'(i);
      end
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      w_edges = w_edges + PW'(r_q[i] ^ r_q[i+1]);
    end
  end

  always_comb begin
    w_legal   = 1'b0;
    w_idx_raw = '0;
    if (MODE == 0) begin
      // A Johnson state is a single run of ones anchored at one end, so it
      // has at most one 0/1 boundary. Filling phase counts ones; draining
      // phase (msb set) counts down from 2*WIDTH.
      w_legal   = (w_edges <= PW'(1));
      w_idx_raw = r_q[WIDTH-1] ? IW'(PW'(2*WIDTH) - w_pop) : IW'(w_pop);
    end else begin
      w_legal   = (w_pop == PW'(1));
      w_idx_raw = w_oh_idx;
    end
  end

  assign w_err = ~w_legal;
  assign w_idx = w_err ? '0 : w_idx_raw;

  // Wrap only from a legal state; a legal state always steps to a legal one.
  assign w_wrap_nxt = ~w_err & (dir ? (w_idx == '0) : (w_idx == c_last_idx));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= c_rst_val;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_q    <= load_val;
      r_wrap <= 1'b0;
    end
`ifdef PARAM_TWISTED_COUNTER_SELF_CORRECT_EN
    else if (w_err) begin
      r_q    <= c_rst_val;
      r_wrap <= 1'b0;
    end
`else
`endif
    else if (en) begin
      r_q    <= w_step;
      r_wrap <= w_wrap_nxt;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign idx  = w_idx;
  assign wrap = r_wrap;
  assign err  = w_err;

endmodule
`default_nettype wire
